zle_p: RTL and testbench

Parametrised zero run-length encoder, the next-generation ZLE stream stage. It converts a stream of DW-bit symbols into tokens: non-zero symbols pass through as literal tokens, and runs of zeros collapse into one run token carrying the run length. Unlike the fixed-width encoder it replaces, it supports parametrised data and count widths, end-of-stream (EOS) flush of partial runs, and full back-pressure on both sides. It sits between a symbol producer and the token packer, using the codebase's valid/back-pressure stream protocol.

---
 rtl/zle_pkg.sv | 17 +
 rtl/zle_p_dp.sv | 74 +++++++
 rtl/zle_p.sv | 128 ++++++++++++
 tb/tb_zle_p.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/zle_pkg.sv
// rtl/zle_pkg.sv - shared types and helpers for the zero run-length encoder
package zle_pkg;

   typedef enum logic [1:0] {START, ZEROS, PEND} state_t;

   localparam logic TOK_LIT = 1'b0;
   localparam logic TOK_RUN = 1'b1;

   // RUN_INC closes a run that includes the current zero; RUN_CUR closes it before a literal
   typedef enum logic [1:0] {SEL_LIT_IN, SEL_RUN_INC, SEL_RUN_CUR, SEL_LIT_PEND} tok_sel_t;
   typedef enum logic [1:0] {CNT_HOLD, CNT_CLR, CNT_SET1, CNT_INC} cnt_op_t;

   function automatic int zle_ow(input int dw, input int cw);
      return 1 + ((dw > cw) ? dw : cw);
   endfunction

endpackage

// File: rtl/zle_p_dp.sv
// rtl/zle_p_dp.sv - run counter, literal latch and token mux for zle_p
module zle_p_dp
   import zle_pkg::*;
#(
   parameter  int DW = 3,
   parameter  int CW = 3,
   localparam int OW = zle_ow(DW, CW)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] d_i,
   input  cnt_op_t       cnt_op_i,
   input  logic          lit_ld_i,
   input  tok_sel_t      tok_sel_i,
   output logic [OW-1:0] tok_o,
   output logic          f_i_eq_0_o,
   output logic          f_cnt_eq_max_m1_o
);

   localparam logic [CW:0] ONE    = {{CW{1'b0}}, 1'b1};
   localparam logic [CW:0] MAX_M1 = {1'b0, {CW{1'b1}}};

   logic [CW:0]   cnt_q, cnt_d, cnt_m1;
   logic [DW-1:0] lit_q, lit_d;

   always_comb begin
      cnt_d = cnt_q;
      case (cnt_op_i)
         CNT_CLR:  cnt_d = '0;
         CNT_SET1: cnt_d = ONE;
         CNT_INC:  cnt_d = cnt_q + ONE;
         default:  cnt_d = cnt_q;
      endcase
      lit_d = lit_ld_i ? d_i : lit_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         lit_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lit_q <= lit_d;
      end
   end

   assign cnt_m1            = cnt_q - ONE;
   assign f_i_eq_0_o        = (d_i == '0);
   assign f_cnt_eq_max_m1_o = (cnt_q == MAX_M1);

   // Run field is length-1: cnt itself when the current zero joins the run
   always_comb begin
      tok_o = '0;
      case (tok_sel_i)
         SEL_LIT_IN: begin
            tok_o[DW-1:0] = d_i;
            tok_o[OW-1]   = TOK_LIT;
         end
         SEL_RUN_INC: begin
            tok_o[CW-1:0] = cnt_q[CW-1:0];
            tok_o[OW-1]   = TOK_RUN;
         end
         SEL_RUN_CUR: begin
            tok_o[CW-1:0] = cnt_m1[CW-1:0];
            tok_o[OW-1]   = TOK_RUN;
         end
         default: begin
            tok_o[DW-1:0] = lit_q;
            tok_o[OW-1]   = TOK_LIT;
         end
      endcase
   end

endmodule

// File: rtl/zle_p.sv
// rtl/zle_p.sv - zero run-length encoder: FSM, output register and back-pressure
module zle_p
   import zle_pkg::*;
#(
   parameter  int DW = 3,
   parameter  int CW = 3,
   localparam int OW = zle_ow(DW, CW)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] i_d,
   input  logic          i_eos,
   input  logic          i_v,
   output logic          i_b,
   output logic [OW-1:0] o_d,
   output logic          o_eos,
   output logic          o_v,
   input  logic          o_b
);

   state_t        state_q, state_d;
   logic          pend_eos_q, pend_eos_d;
   logic [OW-1:0] o_d_q, o_d_d;
   logic          o_v_q, o_v_d, o_eos_q, o_eos_d;

   cnt_op_t       cnt_op;
   tok_sel_t      tok_sel;
   logic          lit_ld, emit, emit_eos, accept, out_free;
   logic          f_i_eq_0, f_cnt_eq_max_m1;
   logic [OW-1:0] tok;

   zle_p_dp #(.DW(DW), .CW(CW)) u_dp (
      .clock             (clock),
      .reset             (reset),
      .d_i               (i_d),
      .cnt_op_i          (cnt_op),
      .lit_ld_i          (lit_ld),
      .tok_sel_i         (tok_sel),
      .tok_o             (tok),
      .f_i_eq_0_o        (f_i_eq_0),
      .f_cnt_eq_max_m1_o (f_cnt_eq_max_m1)
   );

   assign out_free = !o_v_q || !o_b;
   assign i_b      = !reset || (state_q == PEND) || (o_v_q && o_b);
   assign accept   = i_v && !i_b;

   always_comb begin
      state_d    = state_q;
      pend_eos_d = pend_eos_q;
      cnt_op     = CNT_HOLD;
      tok_sel    = SEL_LIT_IN;
      lit_ld     = 1'b0;
      emit       = 1'b0;
      emit_eos   = 1'b0;
      case (state_q)
         START: if (accept) begin
            if (!f_i_eq_0) begin
               emit     = 1'b1;
               emit_eos = i_eos;
            end else if (i_eos) begin
               emit     = 1'b1;
               emit_eos = 1'b1;
               tok_sel  = SEL_RUN_INC;
            end else begin
               cnt_op  = CNT_SET1;
               state_d = ZEROS;
            end
         end
         ZEROS: if (accept) begin
            if (f_i_eq_0 && (i_eos || f_cnt_eq_max_m1)) begin
               emit     = 1'b1;
               emit_eos = i_eos;
               tok_sel  = SEL_RUN_INC;
               cnt_op   = CNT_CLR;
               state_d  = START;
            end else if (f_i_eq_0) begin
               cnt_op = CNT_INC;
            end else begin
               emit       = 1'b1;
               tok_sel    = SEL_RUN_CUR;
               cnt_op     = CNT_CLR;
               lit_ld     = 1'b1;
               pend_eos_d = i_eos;
               state_d    = PEND;
            end
         end
         default: if (out_free) begin
            emit     = 1'b1;
            emit_eos = pend_eos_q;
            tok_sel  = SEL_LIT_PEND;
            state_d  = START;
         end
      endcase
   end

   always_comb begin
      o_v_d   = o_v_q;
      o_d_d   = o_d_q;
      o_eos_d = o_eos_q;
      if (out_free) begin
         o_v_d   = emit;
         o_eos_d = emit && emit_eos;
         if (emit) o_d_d = tok;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= START;
         pend_eos_q <= 1'b0;
         o_v_q      <= 1'b0;
         o_d_q      <= '0;
         o_eos_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_eos_q <= pend_eos_d;
         o_v_q      <= o_v_d;
         o_d_q      <= o_d_d;
         o_eos_q    <= o_eos_d;
      end
   end

   assign o_v   = o_v_q;
   assign o_d   = o_d_q;
   assign o_eos = o_eos_q;

endmodule

// File: tb/tb_zle_p.sv
// tb/tb_zle_p.sv - scoreboard bench for zle_p with DW=3, CW=3
module tb_zle_p;
   import zle_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] i_d   = '0;
   logic       i_eos = 1'b0;
   logic       i_v   = 1'b0;
   logic       i_b;
   logic [3:0] o_d;
   logic       o_eos;
   logic       o_v;
   logic       o_b   = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int stalls = 0;

   logic [4:0] exp_q[$];
   logic       hold_pend = 1'b0;
   logic [5:0] hold_val  = '0;

   zle_p #(.DW(3), .CW(3)) dut (
      .clock (clock),
      .reset (reset),
      .i_d   (i_d),
      .i_eos (i_eos),
      .i_v   (i_v),
      .i_b   (i_b),
      .o_d   (o_d),
      .o_eos (o_eos),
      .o_v   (o_v),
      .o_b   (o_b)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every output transfer pops the scoreboard; stalled outputs must hold
   always @(negedge clock) begin
      if (!reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) check("hold", {2'b0, o_v, o_eos, o_d}, {2'b0, hold_val});
         hold_pend = o_v && o_b;
         hold_val  = {o_v, o_eos, o_d};
         if (o_v && !o_b) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_token: got %b_%b expected none", o_eos, o_d);
            end else begin
               check("token", {3'b0, o_eos, o_d}, {3'b0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic send(input logic [2:0] d, input logic e);
      bit acc = 0;
      int t = 0;
      i_d = d; i_eos = e; i_v = 1'b1;
      while (!acc && t < 200) begin
         @(negedge clock);
         acc = !i_b;
         if (!acc) stalls++;
         @(posedge clock); #1;
         t++;
      end
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: symbol %0d not accepted, required acceptance", d);
      end
      i_v = 1'b0; i_eos = 1'b0; i_d = '0;
   endtask

   initial begin
      // Reset values
      @(negedge clock);
      check("reset_o_v",   {7'b0, o_v},   8'h0);
      check("reset_o_d",   {4'b0, o_d},   8'h0);
      check("reset_o_eos", {7'b0, o_eos}, 8'h0);
      check("reset_i_b",   {7'b0, i_b},   8'h1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Literals pass straight through without stalls
      stalls = 0;
      exp_q.push_back(5'b0_0101);
      exp_q.push_back(5'b0_0011);
      send(3'd5, 1'b0);
      send(3'd3, 1'b0);
      check("lit_stalls", 8'(stalls), 8'd0);

      // Run of three then a literal; one PEND stall cycle
      exp_q.push_back(5'b0_1010);
      exp_q.push_back(5'b0_0110);
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      send(3'd6, 1'b0);
      @(negedge clock);
      check("pend_i_b_hi", {7'b0, i_b}, 8'h1);
      @(negedge clock);
      check("pend_i_b_lo", {7'b0, i_b}, 8'h0);
      @(posedge clock); #1;

      // Max-run wrap, then EOS on a literal closing a short run
      exp_q.push_back(5'b0_1111);
      exp_q.push_back(5'b0_1001);
      exp_q.push_back(5'b1_0001);
      for (int k = 0; k < 10; k++) send(3'd0, 1'b0);
      send(3'd1, 1'b1);
      repeat (2) @(posedge clock); #1;

      // Single zero with EOS
      exp_q.push_back(5'b1_1000);
      send(3'd0, 1'b1);
      @(negedge clock);
      check("eos_state_start", {6'b0, dut.state_q}, {6'b0, START});
      @(posedge clock); #1;

      // Back-pressure: first token held, input stalled, all arrive in order
      for (int k = 1; k <= 4; k++) exp_q.push_back({2'b00, 3'(k)});
      o_b = 1'b1;
      fork
         for (int k = 1; k <= 4; k++) send(3'(k), 1'b0);
         begin
            repeat (5) @(posedge clock); #1;
            o_b = 1'b0;
         end
         begin
            repeat (3) @(negedge clock);
            check("bp_o_d_held", {4'b0, o_d}, 8'h01);
            check("bp_i_b",      {7'b0, i_b}, 8'h1);
         end
      join
      repeat (2) @(posedge clock); #1;

      // Reset mid-run discards the open run
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      send(3'd0, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_o_v_0", {7'b0, o_v}, 8'h0);
      check("rst_i_b_0", {7'b0, i_b}, 8'h1);
      @(negedge clock);
      check("rst_o_v_1", {7'b0, o_v}, 8'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      exp_q.push_back(5'b0_0010);
      send(3'd2, 1'b0);

      begin
         int t = 0;
         while (exp_q.size() != 0 && t < 50) begin
            @(posedge clock); #1;
            t++;
         end
      end
      repeat (4) @(posedge clock); #1;
      check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
